// File: rtl/data_memory_lsu_pkg.sv
// Shared constants, FSM state encoding and access-size decode for the data memory LSU.
package data_memory_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SECOND = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

    // Access size in bytes; the unsigned variants share the low two bits with the signed ones.
    function automatic logic [3:0] access_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store,
                                          input logic is_rv64);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || ((f3 == F3_D) && is_rv64);
        end else begin
            ok = (f3 != 3'b111) && (((f3 != F3_D) && (f3 != F3_WU)) || is_rv64);
        end
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_lsu_byte_ram.sv
// DEPTH x XLEN storage: one synchronous read port (1-cycle latency), one byte-enabled write port.
module dm_byte_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clock,
    input  logic [AW-1:0]     raddr,
    output logic [XLEN-1:0]   rdata,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN/8-1:0] wbe,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // No reset on purpose so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        rdata <= mem[raddr];
        if (we) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_lsu.sv
// RISC-V load/store unit over a byte-enabled word RAM; word-crossing accesses take two beats.
module data_memory_lsu
    import data_memory_lsu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DEPTH         = 256,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] ADDRESS,
    input  logic [XLEN-1:0] WRITE_DATA,
    output logic            resp_valid,
    output logic [XLEN-1:0] READ_DATA,
    output logic            resp_error
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(DEPTH * NB);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready; the
    // response is a single-cycle resp_valid pulse with no backpressure.
    lsu_state_e state, state_d;

    logic              accept;
    logic [OFFW-1:0]   req_off;
    logic [AW-1:0]     req_widx;
    logic [3:0]        req_size;
    logic [XLEN:0]     req_end;
    logic              req_cross;
    logic              req_err;
    logic [2*NB-1:0]   size_mask;
    logic [2*NB-1:0]   st_be_wide;
    logic [2*XLEN-1:0] st_wide;

    logic [OFFW-1:0]   off_q;
    logic [2:0]        f3_q;
    logic              write_q;
    logic              err_q;
    logic              cross_q;
    logic [AW-1:0]     widx_q;
    logic [XLEN-1:0]   hi_data_q;
    logic [NB-1:0]     hi_be_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   read_data_q;

    logic [AW-1:0]     ram_raddr;
    logic [AW-1:0]     ram_waddr;
    logic              ram_we;
    logic [NB-1:0]     ram_wbe;
    logic [XLEN-1:0]   ram_wdata;
    logic [XLEN-1:0]   ram_rdata;

    logic [2*XLEN-1:0] ld_window;
    logic [XLEN-1:0]   ld_raw;
    logic [XLEN-1:0]   ld_ext;
    logic [XLEN-1:0]   resp_rdata;

    assign req_ready = (state == S_IDLE) && reset;
    assign accept    = req_valid && req_ready;

    assign req_off   = ADDRESS[OFFW-1:0];
    assign req_widx  = AW'(ADDRESS >> OFFW);
    assign req_size  = access_bytes(funct3);
    assign req_end   = {1'b0, ADDRESS} + (XLEN+1)'(req_size);
    assign req_cross = (int'(req_off) + int'(req_size)) > NB;
    assign req_err   = !funct3_legal(funct3, req_write, XLEN == 64)
                     || (req_end > MEM_BYTES)
                     || (req_cross && !MISALIGNED_EN);

    // Store data and byte enables laid out across the two-word window {word N+1, word N}.
    assign size_mask  = (2*NB)'((17'd1 << req_size) - 17'd1);
    assign st_be_wide = size_mask << req_off;
    assign st_wide    = {{XLEN{1'b0}}, WRITE_DATA} << {req_off, 3'b000};

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (accept) state_d = (req_cross && !req_err) ? S_SECOND : S_RESP;
            S_SECOND: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_raddr = req_widx;
        ram_waddr = req_widx;
        ram_we    = 1'b0;
        ram_wbe   = st_be_wide[NB-1:0];
        ram_wdata = st_wide[XLEN-1:0];
        if (state == S_SECOND) begin
            ram_raddr = widx_q + 1'b1;
            ram_waddr = widx_q + 1'b1;
            ram_we    = write_q;
            ram_wbe   = hi_be_q;
            ram_wdata = hi_data_q;
        end else if ((state == S_IDLE) && accept && req_write && !req_err) begin
            ram_we = 1'b1;
        end
    end

    dm_byte_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wbe   (ram_wbe),
        .wdata (ram_wdata)
    );

    // A crossing load has word N parked in lo_q while word N+1 arrives from the RAM.
    assign ld_window = cross_q ? {ram_rdata, lo_q} : {{XLEN{1'b0}}, ram_rdata};
    assign ld_raw    = XLEN'(ld_window >> {off_q, 3'b000});

    always_comb begin
        ld_ext = ld_raw;
        unique case (f3_q)
            F3_B:    ld_ext = XLEN'($signed(ld_raw[7:0]));
            F3_H:    ld_ext = XLEN'($signed(ld_raw[15:0]));
            F3_W:    ld_ext = XLEN'($signed(ld_raw[31:0]));
            F3_BU:   ld_ext = XLEN'(ld_raw[7:0]);
            F3_HU:   ld_ext = XLEN'(ld_raw[15:0]);
            F3_WU:   ld_ext = XLEN'(ld_raw[31:0]);
            default: ld_ext = ld_raw;
        endcase
    end

    assign resp_rdata = (err_q || write_q) ? '0 : ld_ext;
    assign resp_valid = (state == S_RESP);
    assign resp_error = resp_valid && err_q;
    assign READ_DATA  = resp_valid ? resp_rdata : read_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            off_q       <= '0;
            f3_q        <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            cross_q     <= 1'b0;
            widx_q      <= '0;
            hi_data_q   <= '0;
            hi_be_q     <= '0;
            lo_q        <= '0;
            read_data_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                off_q     <= req_off;
                f3_q      <= funct3;
                write_q   <= req_write;
                err_q     <= req_err;
                cross_q   <= req_cross && !req_err;
                widx_q    <= req_widx;
                hi_data_q <= st_wide[2*XLEN-1:XLEN];
                hi_be_q   <= st_be_wide[2*NB-1:NB];
            end
            if (state == S_SECOND) lo_q <= ram_rdata;
            if (state == S_RESP) read_data_q <= resp_rdata;
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: vector table through a driver, response scoreboard, reset-in-SECOND sequence.
module tb_data_memory_lsu;
    import data_memory_lsu_pkg::*;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid0 = 1'b0;
    logic            req_valid1 = 1'b0;
    logic            req_write = 1'b0;
    logic [2:0]      funct3 = 3'b000;
    logic [XLEN-1:0] address = '0;
    logic [XLEN-1:0] write_data = '0;
    logic            req_ready0, req_ready1;
    logic            resp_valid0, resp_valid1;
    logic            resp_error0, resp_error1;
    logic [XLEN-1:0] read_data0, read_data1;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [XLEN-1:0] exp_q[$];
    logic            exp_err_q[$];

    typedef struct {
        int              sel;
        logic            w;
        logic [2:0]      f3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] exp;
        logic            err;
        int              lat;
        string           name;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    data_memory_lsu #(.XLEN(XLEN), .DEPTH(256), .MISALIGNED_EN(1'b1)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .funct3(funct3), .ADDRESS(address), .WRITE_DATA(write_data),
        .resp_valid(resp_valid0), .READ_DATA(read_data0), .resp_error(resp_error0)
    );

    data_memory_lsu #(.XLEN(XLEN), .DEPTH(256), .MISALIGNED_EN(1'b0)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write), .funct3(funct3), .ADDRESS(address), .WRITE_DATA(write_data),
        .resp_valid(resp_valid1), .READ_DATA(read_data1), .resp_error(resp_error1)
    );

    function automatic logic rdy(input int s);
        return (s == 0) ? req_ready0 : req_ready1;
    endfunction

    function automatic logic rvld(input int s);
        return (s == 0) ? resp_valid0 : resp_valid1;
    endfunction

    function automatic logic [XLEN-1:0] rdat(input int s);
        return (s == 0) ? read_data0 : read_data1;
    endfunction

    // ---------------- scoreboard ----------------
    logic [XLEN-1:0] mon_d, mon_ed;
    logic            mon_e, mon_ee;

    always @(negedge clock) begin
        if (resp_valid0 || resp_valid1) begin
            mon_d = resp_valid0 ? read_data0 : read_data1;
            mon_e = resp_valid0 ? resp_error0 : resp_error1;
            vec_cnt++;
            if ((resp_valid0 && resp_valid1) || exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_resp: got data=%h err=%b, required no response", mon_d, mon_e);
            end else begin
                mon_ed = exp_q.pop_front();
                mon_ee = exp_err_q.pop_front();
                if (mon_d !== mon_ed || mon_e !== mon_ee) begin
                    err_cnt++;
                    $display("FAIL resp_data: got data=%h err=%b, required data=%h err=%b",
                             mon_d, mon_e, mon_ed, mon_ee);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input vec_t v);
        int   lat;
        logic got;
        @(negedge clock);
        req_write  = v.w;
        funct3     = v.f3;
        address    = v.addr;
        write_data = v.wdata;
        if (v.sel == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
        vec_cnt++;
        if (rdy(v.sel) !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s ready_idle: got %b, required 1", v.name, rdy(v.sel));
        end
        exp_q.push_back(v.exp);
        exp_err_q.push_back(v.err);
        @(posedge clock);
        #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        // Garbage on the request lines while busy must not disturb the access in flight.
        req_write  = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        address    = $urandom;
        write_data = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clock);
            lat++;
            if (rvld(v.sel)) got = 1'b1;
            vec_cnt++;
            if (rdy(v.sel) !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s ready_busy: got %b at cycle %0d, required 0", v.name, rdy(v.sel), lat);
            end
        end
        vec_cnt++;
        if (!got) begin
            err_cnt++;
            $display("FAIL %s timeout: got no resp_valid in %0d cycles, required latency %0d", v.name, lat, v.lat);
            exp_q.delete();
            exp_err_q.delete();
        end else if (lat != v.lat) begin
            err_cnt++;
            $display("FAIL %s latency: got %0d, required %0d", v.name, lat, v.lat);
        end
        @(negedge clock);
        vec_cnt++;
        if (rdat(v.sel) !== v.exp || rdy(v.sel) !== 1'b1 || rvld(v.sel) !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s hold: got data=%h ready=%b valid=%b, required data=%h ready=1 valid=0",
                     v.name, rdat(v.sel), rdy(v.sel), rvld(v.sel), v.exp);
        end
    endtask

    function automatic void add(input int s, input logic w, input logic [2:0] f3,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                                input logic [XLEN-1:0] e, input logic er, input int l,
                                input string n);
        vec_t v;
        v.sel = s; v.w = w; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp = e; v.err = er; v.lat = l; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check_eq(input string n, input logic [XLEN-1:0] got, input logic [XLEN-1:0] req);
        vec_cnt++;
        if (got !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h, required %h", n, got, req);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        // Aligned stores/loads with extension
        add(0, 1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0,        0, 1, "sw_10");
        add(0, 0, F3_B,  32'h13,  32'h0,        32'hFFFFFFDE, 0, 1, "lb_13");
        add(0, 0, F3_BU, 32'h13,  32'h0,        32'h000000DE, 0, 1, "lbu_13");
        add(0, 0, F3_H,  32'h12,  32'h0,        32'hFFFFDEAD, 0, 1, "lh_12");
        add(0, 0, F3_HU, 32'h10,  32'h0,        32'h0000BEEF, 0, 1, "lhu_10");
        add(0, 0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 0, 1, "lw_10");
        add(0, 1, F3_W,  32'h20,  32'h11223344, 32'h0,        0, 1, "sw_20");
        add(0, 1, F3_H,  32'h22,  32'h00008001, 32'h0,        0, 1, "sh_22");
        add(0, 0, F3_W,  32'h20,  32'h0,        32'h80013344, 0, 1, "lw_20a");
        add(0, 0, F3_H,  32'h22,  32'h0,        32'hFFFF8001, 0, 1, "lh_22");
        add(0, 1, F3_B,  32'h21,  32'h0000007F, 32'h0,        0, 1, "sb_21");
        add(0, 0, F3_W,  32'h20,  32'h0,        32'h80017F44, 0, 1, "lw_20b");
        add(0, 0, F3_B,  32'h21,  32'h0,        32'h0000007F, 0, 1, "lb_21_pos");
        // Word-crossing accesses
        add(0, 1, F3_W,  32'h0C,  32'h12345678, 32'h0,        0, 1, "sw_0c");
        add(0, 1, F3_W,  32'h0E,  32'hA1B2C3D4, 32'h0,        0, 2, "sw_0e_cross");
        add(0, 0, F3_W,  32'h0C,  32'h0,        32'hC3D45678, 0, 1, "lw_0c");
        add(0, 0, F3_W,  32'h10,  32'h0,        32'hDEADA1B2, 0, 1, "lw_10_hi");
        add(0, 0, F3_W,  32'h0E,  32'h0,        32'hA1B2C3D4, 0, 2, "lw_0e_cross");
        add(0, 0, F3_H,  32'h0F,  32'h0,        32'hFFFFB2C3, 0, 2, "lh_0f_cross");
        add(0, 0, F3_HU, 32'h0F,  32'h0,        32'h0000B2C3, 0, 2, "lhu_0f_cross");
        add(0, 1, F3_W,  32'h14,  32'h00000000, 32'h0,        0, 1, "sw_14");
        add(0, 1, F3_H,  32'h13,  32'h00009988, 32'h0,        0, 2, "sh_13_cross");
        add(0, 0, F3_W,  32'h10,  32'h0,        32'h88ADA1B2, 0, 1, "lw_10_c");
        add(0, 0, F3_W,  32'h14,  32'h0,        32'h00000099, 0, 1, "lw_14");
        add(0, 0, F3_W,  32'h11,  32'h0,        32'h9988ADA1, 0, 2, "lw_11_cross");
        add(0, 0, F3_B,  32'h13,  32'h0,        32'hFFFFFF88, 0, 1, "lb_13b");
        // Range and funct3 errors
        add(0, 0, F3_W,  32'h400, 32'h0,        32'h0,        1, 1, "lw_400_oob");
        add(0, 1, F3_W,  32'h3FC, 32'hCAFEF00D, 32'h0,        0, 1, "sw_3fc");
        add(0, 1, F3_W,  32'h3FE, 32'h11111111, 32'h0,        1, 1, "sw_3fe_oob");
        add(0, 0, F3_W,  32'h3FC, 32'h0,        32'hCAFEF00D, 0, 1, "lw_3fc");
        add(0, 0, F3_B,  32'h3FF, 32'h0,        32'hFFFFFFCA, 0, 1, "lb_3ff_last");
        add(0, 0, F3_HU, 32'h3FE, 32'h0,        32'h0000CAFE, 0, 1, "lhu_3fe_last");
        add(0, 0, F3_H,  32'h3FF, 32'h0,        32'h0,        1, 1, "lh_3ff_oob");
        add(0, 0, F3_D,  32'h20,  32'h0,        32'h0,        1, 1, "ld_rv32");
        add(0, 0, F3_WU, 32'h20,  32'h0,        32'h0,        1, 1, "lwu_rv32");
        add(0, 0, 3'b111, 32'h20, 32'h0,        32'h0,        1, 1, "load_f3_7");
        add(0, 1, F3_BU, 32'h20,  32'h0,        32'h0,        1, 1, "store_f3_4");
        add(0, 0, F3_W,  32'h20,  32'h0,        32'h80017F44, 0, 1, "lw_20_kept");
        // Misaligned rejection
        add(1, 1, F3_W,  32'h40,  32'h01020304, 32'h0,        0, 1, "m0_sw_40");
        add(1, 0, F3_W,  32'h41,  32'h0,        32'h0,        1, 1, "m0_lw_41");
        add(1, 1, F3_H,  32'h43,  32'h0000FFFF, 32'h0,        1, 1, "m0_sh_43");
        add(1, 0, F3_W,  32'h40,  32'h0,        32'h01020304, 0, 1, "m0_lw_40");
        add(1, 0, F3_H,  32'h42,  32'h0,        32'h00000102, 0, 1, "m0_lh_42");
        add(1, 0, F3_B,  32'h43,  32'h0,        32'h00000001, 0, 1, "m0_lb_43");

        // Reset values while reset is held
        @(negedge clock);
        check_eq("rst_ready0", 32'(req_ready0), 32'h0);
        check_eq("rst_valid0", 32'(resp_valid0), 32'h0);
        check_eq("rst_error0", 32'(resp_error0), 32'h0);
        check_eq("rst_data0", read_data0, 32'h0);
        check_eq("rst_ready1", 32'(req_ready1), 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_rst0", 32'(req_ready0), 32'h1);
        check_eq("ready_after_rst1", 32'(req_ready1), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i]);
        end

        // Reset during the second beat of a crossing store
        add(0, 1, F3_W, 32'h30, 32'h0, 32'h0, 0, 1, "sw_30");
        issue(vecs[vecs.size()-1]);
        add(0, 1, F3_W, 32'h34, 32'h0, 32'h0, 0, 1, "sw_34");
        issue(vecs[vecs.size()-1]);
        @(negedge clock);
        req_write  = 1'b1;
        funct3     = F3_W;
        address    = 32'h32;
        write_data = 32'hA1B2C3D4;
        req_valid0 = 1'b1;
        @(posedge clock);
        #1;
        req_valid0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst2_ready", 32'(req_ready0), 32'h0);
        check_eq("rst2_valid", 32'(resp_valid0), 32'h0);
        check_eq("rst2_error", 32'(resp_error0), 32'h0);
        check_eq("rst2_data", read_data0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst2_ready_after", 32'(req_ready0), 32'h1);
        add(0, 0, F3_W, 32'h30, 32'h0, 32'hC3D40000, 0, 1, "lw_30_first_beat");
        issue(vecs[vecs.size()-1]);
        add(0, 0, F3_W, 32'h34, 32'h0, 32'h00000000, 0, 1, "lw_34_abandoned");
        issue(vecs[vecs.size()-1]);

        repeat (2) @(negedge clock);
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL leftover_expect: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
